mem_access: RTL and testbench

Memory-access stage sitting directly downstream of the execute stage (behind the EX/MEM pipeline register). It consumes the execute result (effective address in `alu_data_i`, store data in `rt_data_i`, `aluop_i`), checks load/store alignment, and drives an SRAM-like data-bus request/response handshake. It shapes store data and byte strobes, extracts and extends load data (including LWL/LWR merges), and stalls the pipeline until the access completes.

---
 rtl/mem_access.sv | 160 ++++++++++++++++
 tb/tb_mem_access.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: MEM stage - alignment checks, data-bus handshake, store shaping and load extraction
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] exception_type_i,
    input  logic [7:0]  aluop_i,
    input  logic        mem_en_i,
    input  logic        mem_to_reg_i,
    input  logic        regfile_wen_i,
    input  logic [4:0]  regfile_waddr_i,
    input  logic [31:0] alu_data_i,
    input  logic [31:0] rt_data_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] exception_type_o,
    output logic        regfile_wen_o,
    output logic [4:0]  regfile_waddr_o,
    output logic [31:0] regfile_wdata_o,
    output logic [31:0] bad_vaddr_o,
    output logic        mem_stall_o
);
    localparam logic [7:0] ALUOP_LB  = 8'h10;
    localparam logic [7:0] ALUOP_LBU = 8'h11;
    localparam logic [7:0] ALUOP_LH  = 8'h12;
    localparam logic [7:0] ALUOP_LHU = 8'h13;
    localparam logic [7:0] ALUOP_LW  = 8'h14;
    localparam logic [7:0] ALUOP_LWL = 8'h15;
    localparam logic [7:0] ALUOP_LWR = 8'h16;
    localparam logic [7:0] ALUOP_SB  = 8'h18;
    localparam logic [7:0] ALUOP_SH  = 8'h19;
    localparam logic [7:0] ALUOP_SW  = 8'h1A;
    localparam logic [7:0] ALUOP_SWL = 8'h1B;
    localparam logic [7:0] ALUOP_SWR = 8'h1C;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CANCEL, S_HOLD} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_rdata;

    logic w_lb, w_lbu, w_lh, w_lhu, w_lw, w_lwl, w_lwr, w_sb, w_sh, w_sw, w_swl, w_swr;
    logic w_load, w_store, w_ade_l, w_ade_s, w_ade, w_issue, w_req, w_unused;
    logic [1:0]  w_off;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata, w_shr, w_lwl_data, w_lwr_data, w_load_data;
    logic [7:0]  w_b;
    logic [15:0] w_h;

    assign w_unused = &{1'b0, mem_en_i, mem_to_reg_i};

    assign w_lb  = aluop_i == ALUOP_LB;
    assign w_lbu = aluop_i == ALUOP_LBU;
    assign w_lh  = aluop_i == ALUOP_LH;
    assign w_lhu = aluop_i == ALUOP_LHU;
    assign w_lw  = aluop_i == ALUOP_LW;
    assign w_lwl = aluop_i == ALUOP_LWL;
    assign w_lwr = aluop_i == ALUOP_LWR;
    assign w_sb  = aluop_i == ALUOP_SB;
    assign w_sh  = aluop_i == ALUOP_SH;
    assign w_sw  = aluop_i == ALUOP_SW;
    assign w_swl = aluop_i == ALUOP_SWL;
    assign w_swr = aluop_i == ALUOP_SWR;

    assign w_load  = w_lb | w_lbu | w_lh | w_lhu | w_lw | w_lwl | w_lwr;
    assign w_store = w_sb | w_sh | w_sw | w_swl | w_swr;
    assign w_off   = alu_data_i[1:0];

    // LWL/LWR/SWL/SWR are never misaligned; they use the word containing the address
    assign w_ade_l = ((w_lh | w_lhu) & w_off[0]) | (w_lw & |w_off);
    assign w_ade_s = (w_sh & w_off[0]) | (w_sw & |w_off);
    assign w_ade   = w_ade_l | w_ade_s;
    assign w_issue = (w_load | w_store) & ~|exception_type_i & ~w_ade & ~flush_i;

    // The request is withdrawn in REQ as soon as a flush arrives
    assign w_req = (r_state == S_IDLE && w_issue) || (r_state == S_REQ && !flush_i);

    // Store strobes and lane-aligned write data; SWL shifts right by 3-off bytes (~off)
    always_comb begin
        w_wstrb = w_sb  ? 4'b0001 << w_off :
                  w_sh  ? (w_off[1] ? 4'b1100 : 4'b0011) :
                  w_sw  ? 4'b1111 :
                  w_swl ? 4'b1111 >> ~w_off :
                  w_swr ? 4'b1111 << w_off : 4'b0000;
        w_wdata = w_sb  ? {4{rt_data_i[7:0]}} :
                  w_sh  ? {2{rt_data_i[15:0]}} :
                  w_swl ? rt_data_i >> {~w_off, 3'b000} :
                  w_swr ? rt_data_i << {w_off, 3'b000} : rt_data_i;
    end

    assign data_req   = w_req;
    assign data_wr    = w_req & w_store;
    assign data_size  = !w_req ? 2'd0 : (w_lb | w_lbu | w_sb) ? 2'd0 : (w_lh | w_lhu | w_sh) ? 2'd1 : 2'd2;
    assign data_addr  = !w_req ? 32'd0 : (w_lwl | w_lwr | w_swl | w_swr) ? {alu_data_i[31:2], 2'b00} : alu_data_i;
    assign data_wdata = (w_req & w_store) ? w_wdata : 32'd0;
    assign data_wstrb = w_req ? w_wstrb : 4'b0000;

    // Load extraction from the captured word; halves are aligned so off is 0 or 2
    always_comb begin
        w_shr       = r_rdata >> {w_off, 3'b000};
        w_b         = w_shr[7:0];
        w_h         = w_shr[15:0];
        w_lwl_data  = w_off == 2'd0 ? {r_rdata[7:0], rt_data_i[23:0]} :
                      w_off == 2'd1 ? {r_rdata[15:0], rt_data_i[15:0]} :
                      w_off == 2'd2 ? {r_rdata[23:0], rt_data_i[7:0]} : r_rdata;
        w_lwr_data  = w_off == 2'd0 ? r_rdata :
                      w_off == 2'd1 ? {rt_data_i[31:24], r_rdata[31:8]} :
                      w_off == 2'd2 ? {rt_data_i[31:16], r_rdata[31:16]} : {rt_data_i[31:8], r_rdata[31:24]};
        w_load_data = w_lb  ? {{24{w_b[7]}}, w_b} :
                      w_lbu ? {24'd0, w_b} :
                      w_lh  ? {{16{w_h[15]}}, w_h} :
                      w_lhu ? {16'd0, w_h} :
                      w_lwl ? w_lwl_data :
                      w_lwr ? w_lwr_data : r_rdata;
    end

    assign pc_o             = pc_i;
    assign exception_type_o = {exception_type_i[31:25], exception_type_i[24] | w_ade_l,
                               exception_type_i[23] | w_ade_s, exception_type_i[22:0]};
    assign bad_vaddr_o      = w_ade ? alu_data_i : 32'd0;
    assign regfile_wen_o    = regfile_wen_i & ~w_ade & ~flush_i;
    assign regfile_waddr_o  = regfile_waddr_i;
    assign regfile_wdata_o  = w_load ? w_load_data : alu_data_i;
    assign mem_stall_o      = (r_state == S_IDLE && w_issue) || r_state == S_REQ || r_state == S_WAIT ||
                              r_state == S_CANCEL || (r_state == S_HOLD && stall_i);

    // Next-state logic for the single-outstanding bus transaction
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = !w_issue ? S_IDLE : data_addr_ok ? S_WAIT : S_REQ;
            S_REQ:    w_next = flush_i ? S_IDLE : data_addr_ok ? S_WAIT : S_REQ;
            S_WAIT:   w_next = data_data_ok ? (flush_i ? S_IDLE : S_HOLD) : (flush_i ? S_CANCEL : S_WAIT);
            S_CANCEL: w_next = data_data_ok ? S_IDLE : S_CANCEL;
            S_HOLD:   w_next = (!stall_i || flush_i) ? S_IDLE : S_HOLD;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register and read-data capture; a flushed response is never captured
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT && data_data_ok && !flush_i)
                r_rdata <= data_rdata;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for the MEM stage
module tb_mem_access;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_LB  = 8'h10;
    localparam logic [7:0] OP_LBU = 8'h11;
    localparam logic [7:0] OP_LW  = 8'h14;
    localparam logic [7:0] OP_LWR = 8'h16;
    localparam logic [7:0] OP_SB  = 8'h18;
    localparam logic [7:0] OP_SH  = 8'h19;
    localparam logic [7:0] OP_SWL = 8'h1B;
    localparam logic [7:0] OP_SWR = 8'h1C;

    logic clk = 0, rst = 0;
    logic flush_i = 0, stall_i = 0;
    logic [31:0] pc_i = 0, exception_type_i = 0;
    logic [7:0] aluop_i = 0;
    logic mem_en_i = 0, mem_to_reg_i = 0, regfile_wen_i = 0;
    logic [4:0] regfile_waddr_i = 0;
    logic [31:0] alu_data_i = 0, rt_data_i = 0;
    logic data_req, data_wr;
    logic [1:0] data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0] data_wstrb;
    logic data_addr_ok = 0, data_data_ok = 0;
    logic [31:0] data_rdata = 0;
    logic [31:0] pc_o, exception_type_o, regfile_wdata_o, bad_vaddr_o;
    logic regfile_wen_o, mem_stall_o;
    logic [4:0] regfile_waddr_o;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
        .pc_i(pc_i), .exception_type_i(exception_type_i), .aluop_i(aluop_i),
        .mem_en_i(mem_en_i), .mem_to_reg_i(mem_to_reg_i), .regfile_wen_i(regfile_wen_i),
        .regfile_waddr_i(regfile_waddr_i), .alu_data_i(alu_data_i), .rt_data_i(rt_data_i),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .pc_o(pc_o),
        .exception_type_o(exception_type_o), .regfile_wen_o(regfile_wen_o),
        .regfile_waddr_o(regfile_waddr_o), .regfile_wdata_o(regfile_wdata_o),
        .bad_vaddr_o(bad_vaddr_o), .mem_stall_o(mem_stall_o)
    );

    task automatic nop();
        aluop_i = 0; alu_data_i = 0; rt_data_i = 0; regfile_wen_i = 0; mem_en_i = 0;
        mem_to_reg_i = 0; exception_type_i = 0; flush_i = 0; data_addr_ok = 0; data_data_ok = 0;
    endtask

    task automatic go(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt);
        aluop_i = op; alu_data_i = addr; rt_data_i = rt; regfile_wen_i = 1; regfile_waddr_i = 5'd3;
        mem_en_i = 1; mem_to_reg_i = 1;
    endtask

    // Accept in the current cycle, respond in the next, return at the HOLD cycle
    task automatic complete();
        data_addr_ok = 1;
        @(negedge clk); data_addr_ok = 0; data_data_ok = 1;
        @(negedge clk); data_data_ok = 0;
    endtask

    task automatic test_reset();
        nop(); rst = 0;
        @(negedge clk); #1;
        vecs++; if (data_req !== 1'b0) begin errs++; $display("FAIL reset_req got %b exp 0", data_req); end
        vecs++; if (mem_stall_o !== 1'b0) begin errs++; $display("FAIL reset_stall got %b exp 0", mem_stall_o); end
        vecs++; if (regfile_wdata_o !== 32'd0) begin errs++; $display("FAIL reset_wdata got %h exp 0", regfile_wdata_o); end
        rst = 1;
    endtask

    task automatic test_lw();
        @(negedge clk); go(OP_LW, 32'h80000004, 32'h0); data_addr_ok = 1; #1;
        vecs++; if (data_req !== 1'b1) begin errs++; $display("FAIL lw_req got %b exp 1", data_req); end
        vecs++; if (data_addr !== 32'h80000004) begin errs++; $display("FAIL lw_addr got %h exp 80000004", data_addr); end
        vecs++; if (data_size !== 2'd2) begin errs++; $display("FAIL lw_size got %0d exp 2", data_size); end
        vecs++; if (mem_stall_o !== 1'b1) begin errs++; $display("FAIL lw_stall_c0 got %b exp 1", mem_stall_o); end
        @(negedge clk); data_addr_ok = 0; #1;
        vecs++; if (mem_stall_o !== 1'b1 || data_req !== 1'b0) begin errs++; $display("FAIL lw_c1 stall %b req %b exp 1 0", mem_stall_o, data_req); end
        @(negedge clk); data_data_ok = 1; data_rdata = 32'h12345678; #1;
        vecs++; if (mem_stall_o !== 1'b1) begin errs++; $display("FAIL lw_stall_c2 got %b exp 1", mem_stall_o); end
        @(negedge clk); data_data_ok = 0; data_rdata = 0; #1;
        vecs++; if (mem_stall_o !== 1'b0) begin errs++; $display("FAIL lw_stall_c3 got %b exp 0", mem_stall_o); end
        vecs++; if (regfile_wdata_o !== 32'h12345678) begin errs++; $display("FAIL lw_wdata got %h exp 12345678", regfile_wdata_o); end
        vecs++; if (regfile_wen_o !== 1'b1) begin errs++; $display("FAIL lw_wen got %b exp 1", regfile_wen_o); end
    endtask

    task automatic test_lb_lbu();
        @(negedge clk); go(OP_LB, 32'h80000003, 32'h0); data_rdata = 32'h80FF0011; #1;
        vecs++; if (data_size !== 2'd0) begin errs++; $display("FAIL lb_size got %0d exp 0", data_size); end
        vecs++; if (data_wstrb !== 4'b0000) begin errs++; $display("FAIL lb_wstrb got %b exp 0000", data_wstrb); end
        complete(); #1;
        vecs++; if (regfile_wdata_o !== 32'hFFFFFF80) begin errs++; $display("FAIL lb_wdata got %h exp ffffff80", regfile_wdata_o); end
        @(negedge clk); go(OP_LBU, 32'h80000003, 32'h0); complete(); #1;
        vecs++; if (regfile_wdata_o !== 32'h00000080) begin errs++; $display("FAIL lbu_wdata got %h exp 00000080", regfile_wdata_o); end
        vecs++; if (mem_stall_o !== 1'b0) begin errs++; $display("FAIL lbu_stall got %b exp 0", mem_stall_o); end
        @(negedge clk); nop(); data_rdata = 0;
    endtask

    task automatic test_stores();
        @(negedge clk); go(OP_SWL, 32'h80000002, 32'hAABBCCDD); #1;
        vecs++; if (data_addr !== 32'h80000000) begin errs++; $display("FAIL swl_addr got %h exp 80000000", data_addr); end
        vecs++; if (data_wstrb !== 4'b0111) begin errs++; $display("FAIL swl_wstrb got %b exp 0111", data_wstrb); end
        vecs++; if (data_wdata !== 32'h00AABBCC) begin errs++; $display("FAIL swl_wdata got %h exp 00aabbcc", data_wdata); end
        vecs++; if (data_wr !== 1'b1) begin errs++; $display("FAIL swl_wr got %b exp 1", data_wr); end
        complete();
        @(negedge clk); go(OP_SWR, 32'h80000001, 32'hAABBCCDD); #1;
        vecs++; if (data_wstrb !== 4'b1110) begin errs++; $display("FAIL swr_wstrb got %b exp 1110", data_wstrb); end
        vecs++; if (data_wdata !== 32'hBBCCDD00) begin errs++; $display("FAIL swr_wdata got %h exp bbccdd00", data_wdata); end
        complete();
        @(negedge clk); go(OP_SB, 32'h80000001, 32'h000000A5); #1;
        vecs++; if (data_wstrb !== 4'b0010) begin errs++; $display("FAIL sb_wstrb got %b exp 0010", data_wstrb); end
        vecs++; if (data_wdata !== 32'hA5A5A5A5) begin errs++; $display("FAIL sb_wdata got %h exp a5a5a5a5", data_wdata); end
        complete();
        @(negedge clk); go(OP_SH, 32'h80000002, 32'h1234BEEF); #1;
        vecs++; if (data_wstrb !== 4'b1100) begin errs++; $display("FAIL sh_wstrb got %b exp 1100", data_wstrb); end
        vecs++; if (data_wdata !== 32'hBEEFBEEF) begin errs++; $display("FAIL sh_wdata got %h exp beefbeef", data_wdata); end
        vecs++; if (data_size !== 2'd1) begin errs++; $display("FAIL sh_size got %0d exp 1", data_size); end
        complete();
        @(negedge clk); nop();
    endtask

    task automatic test_misaligned();
        @(negedge clk); go(OP_LW, 32'h80000002, 32'h0); #1;
        vecs++; if (data_req !== 1'b0) begin errs++; $display("FAIL adel_req got %b exp 0", data_req); end
        vecs++; if (exception_type_o !== 32'h01000000) begin errs++; $display("FAIL adel_exc got %h exp 01000000", exception_type_o); end
        vecs++; if (bad_vaddr_o !== 32'h80000002) begin errs++; $display("FAIL adel_badv got %h exp 80000002", bad_vaddr_o); end
        vecs++; if (regfile_wen_o !== 1'b0 || mem_stall_o !== 1'b0) begin errs++; $display("FAIL adel_wen_stall got %b %b exp 0 0", regfile_wen_o, mem_stall_o); end
        @(negedge clk); go(OP_SH, 32'h80000001, 32'h0); #1;
        vecs++; if (exception_type_o !== 32'h00800000 || data_req !== 1'b0) begin errs++; $display("FAIL ades got exc %h req %b exp 00800000 0", exception_type_o, data_req); end
        @(negedge clk); go(OP_LW, 32'h80000008, 32'h0); exception_type_i = 32'h100; #1;
        vecs++; if (data_req !== 1'b0 || mem_stall_o !== 1'b0 || exception_type_o !== 32'h100) begin errs++; $display("FAIL excin got req %b stall %b exc %h exp 0 0 100", data_req, mem_stall_o, exception_type_o); end
        @(negedge clk); nop();
    endtask

    task automatic test_passthrough();
        @(negedge clk); go(OP_ADD, 32'hDEADBEEF, 32'h0); pc_i = 32'hBFC00010; #1;
        vecs++; if (regfile_wdata_o !== 32'hDEADBEEF) begin errs++; $display("FAIL alu_wdata got %h exp deadbeef", regfile_wdata_o); end
        vecs++; if (data_req !== 1'b0 || mem_stall_o !== 1'b0) begin errs++; $display("FAIL alu_bus got req %b stall %b exp 0 0", data_req, mem_stall_o); end
        vecs++; if (pc_o !== 32'hBFC00010 || regfile_waddr_o !== 5'd3) begin errs++; $display("FAIL alu_pass got pc %h waddr %0d exp bfc00010 3", pc_o, regfile_waddr_o); end
        @(negedge clk); nop();
    endtask

    task automatic test_flush();
        @(negedge clk); go(OP_LW, 32'h80000010, 32'h0); data_addr_ok = 1;
        @(negedge clk); data_addr_ok = 0; flush_i = 1; #1;
        vecs++; if (mem_stall_o !== 1'b1 || regfile_wen_o !== 1'b0) begin errs++; $display("FAIL flush_wait got stall %b wen %b exp 1 0", mem_stall_o, regfile_wen_o); end
        @(negedge clk); nop(); #1;
        vecs++; if (mem_stall_o !== 1'b1 || data_req !== 1'b0) begin errs++; $display("FAIL cancel_c0 got stall %b req %b exp 1 0", mem_stall_o, data_req); end
        @(negedge clk); #1;
        vecs++; if (mem_stall_o !== 1'b1) begin errs++; $display("FAIL cancel_c1 got stall %b exp 1", mem_stall_o); end
        data_data_ok = 1;
        @(negedge clk); data_data_ok = 0; #1;
        vecs++; if (mem_stall_o !== 1'b0 || data_req !== 1'b0 || regfile_wen_o !== 1'b0) begin errs++; $display("FAIL cancel_end got stall %b req %b wen %b exp 0 0 0", mem_stall_o, data_req, regfile_wen_o); end
        @(negedge clk); go(OP_LW, 32'h80000020, 32'h0);
        @(negedge clk); data_data_ok = 1; #1;
        vecs++; if (data_req !== 1'b1 || mem_stall_o !== 1'b1 || data_addr !== 32'h80000020) begin errs++; $display("FAIL req_hold got req %b stall %b addr %h exp 1 1 80000020", data_req, mem_stall_o, data_addr); end
        data_data_ok = 0; flush_i = 1; #1;
        vecs++; if (data_req !== 1'b0) begin errs++; $display("FAIL req_flush got req %b exp 0", data_req); end
        @(negedge clk); nop(); #1;
        vecs++; if (mem_stall_o !== 1'b0 || data_req !== 1'b0) begin errs++; $display("FAIL req_flush_idle got stall %b req %b exp 0 0", mem_stall_o, data_req); end
    endtask

    task automatic test_lwr_hold();
        @(negedge clk); go(OP_LWR, 32'h80000042, 32'h11223344); data_rdata = 32'hAABBCCDD; #1;
        vecs++; if (data_addr !== 32'h80000040) begin errs++; $display("FAIL lwr_addr got %h exp 80000040", data_addr); end
        complete(); stall_i = 1; data_rdata = 32'h0; data_data_ok = 1; #1;
        vecs++; if (regfile_wdata_o !== 32'h1122AABB || mem_stall_o !== 1'b1) begin errs++; $display("FAIL lwr_h0 got %h stall %b exp 1122aabb 1", regfile_wdata_o, mem_stall_o); end
        @(negedge clk); #1;
        vecs++; if (regfile_wdata_o !== 32'h1122AABB || mem_stall_o !== 1'b1) begin errs++; $display("FAIL lwr_h1 got %h stall %b exp 1122aabb 1", regfile_wdata_o, mem_stall_o); end
        @(negedge clk); stall_i = 0; data_data_ok = 0; #1;
        vecs++; if (regfile_wdata_o !== 32'h1122AABB || mem_stall_o !== 1'b0) begin errs++; $display("FAIL lwr_h2 got %h stall %b exp 1122aabb 0", regfile_wdata_o, mem_stall_o); end
        @(negedge clk); nop();
    endtask

    task automatic test_async_reset();
        @(negedge clk); go(OP_LW, 32'h80000030, 32'h0);
        @(negedge clk); nop(); #1;
        vecs++; if (mem_stall_o !== 1'b1) begin errs++; $display("FAIL areset_pre got stall %b exp 1", mem_stall_o); end
        #1 rst = 0; #1;
        vecs++; if (mem_stall_o !== 1'b0) begin errs++; $display("FAIL areset got stall %b exp 0", mem_stall_o); end
        @(negedge clk); rst = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_stores();
        test_misaligned();
        test_passthrough();
        test_flush();
        test_lwr_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
